// File: rtl/alu_cmd_pkg.sv
// Shared constants and types for the ALU command issuer.
package alu_cmd_pkg;

    localparam int unsigned ALU_DATA_W = 8;
    localparam int unsigned ALU_OP_W   = 3;
    localparam int unsigned CMD_DEPTH  = 4;

    // ALU opcodes
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'd0;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd3;
    localparam logic [ALU_OP_W-1:0] OP_SHL = 3'd4;
    localparam logic [ALU_OP_W-1:0] OP_SHR = 3'd5;
    localparam logic [ALU_OP_W-1:0] OP_NOT = 3'd6;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd7;

    // Issue FSM; capture happens on the ISSUE->RESP edge
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Command record as stored in the FIFO: {opcode, a, b, chain}
    typedef struct packed {
        logic [ALU_OP_W-1:0]   opcode;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic                  chain;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on rd_data while non-empty.
module alu_cmd_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Front-end that queues ALU commands, issues them one at a time and returns
// masked results in order on a valid/ready response stream.
module alu_cmd_issuer
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned OP_W   = ALU_OP_W,
    parameter int unsigned DEPTH  = CMD_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic              busy,
    output logic [7:0]        op_count
);

    localparam int unsigned REC_W = OP_W + 2 * DATA_W + 1;

    state_t            state;
    state_t            next_state;
    logic              pop;
    logic              capture;
    logic              retire;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REC_W-1:0]  fifo_wr;
    logic [REC_W-1:0]  fifo_rd;
    logic [OP_W-1:0]   head_opcode;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic              head_chain;
    logic [DATA_W-1:0] acc;
    logic              op_is_add;
    logic              same_sign;

    assign fifo_wr = {cmd_opcode, cmd_a, cmd_b, cmd_chain};
    assign {head_opcode, head_a, head_b, head_chain} = fifo_rd;

    alu_cmd_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid),
        .wr_data (fifo_wr),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // No pass-through: a full FIFO refuses even when a pop happens this cycle
    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    assign op_is_add = (alu_opcode == OP_W'(OP_ADD));
    assign same_sign = (alu_a[DATA_W-1] == alu_b[DATA_W-1]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_RESP;
            ST_RESP:  if (rsp_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        retire  = 1'b0;
        case (state)
            ST_IDLE:  pop     = !fifo_empty;
            ST_ISSUE: capture = 1'b1;
            ST_RESP:  retire  = rsp_valid && rsp_ready;
            default:  ;
        endcase
    end

    // ALU operand/opcode registers; they hold their last values between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else if (pop) begin
            alu_a      <= head_chain ? acc : head_a;
            alu_b      <= head_b;
            alu_opcode <= head_opcode;
        end
    end

    // Result capture with flag masking, accumulator update and response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            acc          <= '0;
            op_count     <= '0;
        end else if (capture) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_carry    <= op_is_add && alu_carry;
            rsp_overflow <= op_is_add && alu_overflow && same_sign;
            acc          <= alu_result;
        end else if (retire) begin
            rsp_valid    <= 1'b0;
            op_count     <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU and scoreboard.
module tb_alu_cmd_issuer;
    import alu_cmd_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_carry;
    logic       rsp_overflow;
    logic       busy;
    logic [7:0] op_count;

    alu_cmd_issuer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_chain    (cmd_chain),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .busy         (busy),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external ALU; non-ADD ops raise raw carry/overflow so masking is visible
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide     = '0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_opcode)
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_ADD: begin
                alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = alu_wide[7:0];
                alu_carry    = alu_wide[8];
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_wide[7] != alu_a[7]);
            end
            OP_SUB: begin
                alu_wide     = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result   = alu_wide[7:0];
                alu_carry    = alu_wide[8];
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_wide[7] != alu_a[7]);
            end
            OP_SHL: begin
                alu_result = alu_a << alu_b[2:0];
                alu_carry  = alu_a[7];
            end
            OP_SHR: begin
                alu_result = alu_a >> alu_b[2:0];
                alu_carry  = alu_a[0];
            end
            OP_NOT: begin
                alu_result   = ~alu_a;
                alu_carry    = 1'b1;
                alu_overflow = 1'b1;
            end
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] acc_m = 8'h00;
    int         n_pushed = 0;
    bit         rnd_done = 1'b0;
    vec_t       tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected response computed from the opcode definitions with integer arithmetic
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sum;
        int   ssum;
        int   sh;
        e.a  = a;
        e.b  = b;
        e.op = op;
        e.c  = 1'b0;
        e.v  = 1'b0;
        sh   = int'(b) % 8;
        case (op)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_XOR: e.res = a ^ b;
            OP_NOT: e.res = ~a;
            OP_ADD: begin
                sum   = int'(a) + int'(b);
                ssum  = int'($signed(a)) + int'($signed(b));
                e.res = 8'(sum);
                e.c   = (sum > 255);
                e.v   = (ssum > 127) || (ssum < -128);
            end
            OP_SUB: e.res = 8'(int'(a) - int'(b));
            OP_SHL: e.res = 8'(int'(a) << sh);
            default: e.res = 8'(int'(a) >> sh);
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic chain);
        exp_t e;
        bit   ok;
        ok         = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_chain  = chain;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                ok    = 1'b1;
                e     = model(op, chain ? acc_m : a, b);
                acc_m = e.res;
                exp_q.push_back(e);
                n_pushed++;
            end
        end
        #1;
        cmd_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_arrives", 32'(got), 32'd1);
    endtask

    // Scoreboard: every response handshake is checked against the in-order model queue
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_result", 32'(rsp_result), 32'(mon_e.res));
                chk("sb_zero", 32'(rsp_zero), 32'(mon_e.z));
                chk("sb_carry", 32'(rsp_carry), 32'(mon_e.c));
                chk("sb_overflow", 32'(rsp_overflow), 32'(mon_e.v));
                chk("sb_alu_a", 32'(alu_a), 32'(mon_e.a));
                chk("sb_alu_b", 32'(alu_b), 32'(mon_e.b));
                chk("sb_alu_opcode", 32'(alu_opcode), 32'(mon_e.op));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int prev;
        tbl[0]  = '{OP_ADD, 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{OP_AND, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{OP_SUB, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{OP_OR,  8'hEE, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{OP_SHL, 8'h81, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{OP_SHR, 8'h03, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{OP_NOT, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{OP_XOR, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{OP_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_chain  = 1'b0;
        rsp_ready  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, one at a time with an always-ready consumer
        rsp_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            push(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].chain);
            wait_rsp(n);
            chk("vec_latency", 32'(n), 32'd3);
            chk("vec_result", 32'(rsp_result), 32'(tbl[i].res));
            chk("vec_zero", 32'(rsp_zero), 32'(tbl[i].z));
            chk("vec_carry", 32'(rsp_carry), 32'(tbl[i].c));
            chk("vec_overflow", 32'(rsp_overflow), 32'(tbl[i].v));
            if (tbl[i].chain) chk("vec_chain_alu_a", 32'(alu_a), 32'h00);
            @(posedge clk);
            #1;
            chk("vec_busy_after", 32'(busy), 32'd0);
            if (i == 0) chk("vec_op_count_first", 32'(op_count), 32'd1);
        end
        chk("table_op_count", 32'(op_count), 32'd13);

        // Backpressure: stalled response with a filling FIFO
        rsp_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push(OP_ADD, 8'(k), 8'(k), 1'b0);
            if (k == 4) chk("bp_ready_before_full", 32'(cmd_ready), 32'd1);
        end
        chk("bp_ready_full", 32'(cmd_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hold_result", 32'(rsp_result), 32'h02);
        chk("bp_hold_full", 32'(cmd_ready), 32'd0);
        chk("bp_hold_busy", 32'(busy), 32'd1);
        chk("bp_hold_op_count", 32'(op_count), 32'd13);
        rsp_ready = 1'b1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(n);
            chk("bp_result", 32'(rsp_result), 32'((k + 1) * 2));
            if (k > 0) chk("bp_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
            @(posedge clk);
            #1;
            if (k < 4) chk("bp_busy_mid", 32'(busy), 32'd1);
        end
        chk("bp_busy_end", 32'(busy), 32'd0);
        chk("bp_op_count", 32'(op_count), 32'd18);

        // Reset while a response is pending and two commands are queued
        rsp_ready = 1'b0;
        push(OP_ADD, 8'h11, 8'h22, 1'b0);
        push(OP_XOR, 8'h33, 8'h44, 1'b0);
        push(OP_OR,  8'h55, 8'h66, 1'b0);
        wait_rsp(n);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_m    = 8'h00;
        n_pushed = 0;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_busy_clr", 32'(busy), 32'd0);
        chk("mid_op_count", 32'(op_count), 32'd0);
        chk("mid_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rsp_result", 32'(rsp_result), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        push(OP_ADD, 8'h77, 8'h03, 1'b1);
        wait_rsp(n);
        chk("post_rst_latency", 32'(n), 32'd3);
        chk("post_rst_result", 32'(rsp_result), 32'h03);
        chk("post_rst_alu_a", 32'(alu_a), 32'h00);
        @(posedge clk);
        #1;
        chk("post_rst_busy_end", 32'(busy), 32'd0);
        chk("post_rst_op_count", 32'(op_count), 32'd1);

        // Random traffic with random consumer stalls; enough responses to wrap op_count
        fork
            begin
                for (int i = 0; i < 270; i++) begin
                    push(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                         1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        chk("rnd_busy_end", 32'(busy), 32'd0);
        chk("rnd_op_count_wrap", 32'(op_count), 32'(8'(n_pushed)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
